fetch_prefetch_unit: RTL and testbench
======================================

# fetch_prefetch_unit

Parametrised instruction-fetch front end with a decoupling prefetch queue. It sits between the redirect sources (exception, jump and branch resolution) and decode. It issues fetch requests to the instruction cache over a valid/ready request and valid response interface that tolerates variable latency. It buffers up to DEPTH fetched instructions and discards in-flight responses made stale by a redirect.

## Interface
- XLEN, 32, address/instruction width (≥8)
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, fetch address after reset (XLEN bits, low 2 bits zero)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- exception  in  1  highest-priority redirect
- exception_target  in  XLEN  exception redirect address
- jump  in  1  second-priority redirect
- jump_target  in  XLEN  jump address
- branch  in  1  lowest-priority redirect (taken branch)
- branch_target  in  XLEN  branch address
- req_valid  out  1  fetch request to icache
- req_addr  out  XLEN  fetch address
- req_ready  in  1  icache accepts request when req_valid & req_ready
- rsp_valid  in  1  icache returns one instruction; never in the accept cycle
- rsp_data  in  XLEN  returned instruction
- out_valid  out  1  queue head valid toward decode
- out_pc  out  XLEN  PC of head
- out_instr  out  XLEN  instruction of head
- out_ready  in  1  decode consumes head when out_valid & out_ready (low = external stall)
- drop_count  out  16  saturating count of discarded stale responses

## Operation
- State: fetch_pc; FSM IDLE/WAIT; req_pc; stale flag; queue (DEPTH × {pc, instr}) with head/tail pointers and a count of 0..DEPTH.
- Redirect = exception | jump | branch. Target is chosen by priority exception > jump > branch. Bits [1:0] of the target are forced to 0.
- Redirect cycle:
  - queue flushed (count 0, head = tail);
  - fetch_pc <= target;
  - req_valid forced 0;
  - if FSM is WAIT, stale <= 1.
- IDLE: req_valid = ~redirect & ~stale & (count < DEPTH), with req_addr = fetch_pc.
  - On accept: req_pc <= fetch_pc; fetch_pc <= fetch_pc + 4 (mod 2^XLEN); go to WAIT.
  - A request that is not accepted may change address or drop on a redirect.
- WAIT: req_valid = 0. On rsp_valid, go to IDLE.
  - If stale, or a redirect occurs in the same cycle: discard the response, clear stale, and increment drop_count (saturating at 16'hFFFF).
  - Otherwise push {req_pc, rsp_data} at tail.
- Space is checked at issue. One outstanding request at most, so a push never overflows. Push and pop in the same cycle leave count unchanged.
- out_valid = (count != 0). out_pc and out_instr come from the head entry. Pop on out_valid & out_ready. Flush overrides push and pop in the same cycle.
- Ignored inputs:
  - rsp_valid in IDLE;
  - req_ready when req_valid = 0.

## Timing
- Reset (asynchronous) values:
  - fetch_pc = RESET_PC;
  - FSM IDLE, stale 0, count 0, drop_count 0;
  - out_valid 0, req_valid 0 while reset is high.
- First cycle after reset deassertion: req_valid = 1, req_addr = RESET_PC.
- Latency: accept at cycle t, rsp_valid no earlier than t+1, out_valid at the cycle after the push.
- Throughput: best case one instruction per 2 cycles, because IDLE and WAIT alternate.
- Redirect at cycle t:
  - out_valid = 0 from t+1;
  - req_addr = target at t+1 if IDLE;
  - otherwise the new request follows the cycle after the stale response returns.
- Stall: with out_ready low the queue fills to DEPTH and req_valid stays 0 until a pop. The pop cycle frees space combinationally only on the following cycle.
- Reset mid-WAIT: the outstanding request is forgotten. The icache is reset by the same signal.

## Test plan
- Reset, then req_ready = 1 with response latency 1 and out_ready = 1:
  - requests 0x0, 0x4, 0x8 in order;
  - outputs (pc, instr) match in order, one every 2 cycles.
- out_ready = 0 with DEPTH = 4:
  - exactly 4 accepts, then req_valid stays 0 and count = 4;
  - after one pop, exactly one more request is issued.
- Branch to 0x103 while WAIT for 0x8 (latency 5):
  - the 0x8 response is dropped and drop_count = 1;
  - the next req_addr is 0x100 and out_pc begins at 0x100.
- exception (target 0x80), jump (0x40) and branch (0x20) in the same cycle, with 3 entries queued:
  - queue empty next cycle;
  - req_addr = 0x80.
- rsp_valid coincident with a jump:
  - the response is discarded and not pushed;
  - fetch resumes at the jump target.
- fetch_pc = 0xFFFF_FFFC with XLEN = 32:
  - the next request wraps to 0x0;
  - force 65,540 stale drops and confirm drop_count saturates at 0xFFFF.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: one outstanding icache request, DEPTH-entry {pc,instr} queue, redirect flush.
// Head visible the cycle after a push; no issue while the queue is full or a stale response is due.
module fetch_prefetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            exception,
    input  logic [XLEN-1:0] exception_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_target,
    output logic            req_valid,
    output logic [XLEN-1:0] req_addr,
    input  logic            req_ready,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    input  logic            out_ready,
    output logic [15:0]     drop_count
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            stale_q, stale_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     drop_count_q, drop_count_d;
    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            accept;
    logic            rsp_take;
    logic            discard;
    logic            push;
    logic            pop;

    assign redirect = exception | jump | branch;

    always_comb begin
        target = branch_target;
        if (exception) begin
            target = exception_target;
        end else if (jump) begin
            target = jump_target;
        end
        target[1:0] = 2'b00;
    end

    // Gated by reset so nothing is offered to the icache while it is also held in reset.
    assign req_valid = ~reset & (state_q == S_IDLE) & ~redirect & ~stale_q
                     & (count_q < CW'(DEPTH));
    assign req_addr  = fetch_pc_q;

    assign accept   = req_valid & req_ready;
    assign rsp_take = (state_q == S_WAIT) & rsp_valid;
    assign discard  = rsp_take & (stale_q | redirect);
    assign push     = rsp_take & ~discard;
    assign pop      = out_valid & out_ready;

    assign out_valid  = (count_q != '0);
    assign out_pc     = pc_mem_q[head_q];
    assign out_instr  = instr_mem_q[head_q];
    assign drop_count = drop_count_q;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        stale_d      = stale_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        drop_count_d = drop_count_q;

        if (accept) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            state_d    = S_WAIT;
        end

        // A returning response always settles the outstanding request, even alongside a redirect.
        if (rsp_take) begin
            state_d = S_IDLE;
            stale_d = 1'b0;
        end else if (redirect && state_q == S_WAIT) begin
            stale_d = 1'b1;
        end

        if (discard && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end

        if (push) tail_d = tail_q + PW'(1);
        if (pop)  head_d = head_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (redirect) begin
            fetch_pc_d = target;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= '0;
            stale_q      <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            stale_q      <= stale_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[tail_q]    <= req_pc_q;
            instr_mem_q[tail_q] <= rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a small variable-latency icache responder.
// Instruction returned for address a is a ^ MAGIC.
module tb_fetch_prefetch_unit;
    localparam logic [31:0] MAGIC = 32'h1234_5670;

    logic        clk;
    logic        reset;
    logic        exception;
    logic [31:0] exception_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch;
    logic [31:0] branch_target;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [15:0] drop_count;

    int          pass_cnt;
    int          total_cnt;
    int          lat;
    int          pend_cnt;
    logic [31:0] pend_addr;
    int          cyc;
    logic [31:0] acc_log [$];
    logic [31:0] pop_pc  [$];
    logic [31:0] pop_ins [$];
    int          pop_cyc [$];

    fetch_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .exception(exception), .exception_target(exception_target),
        .jump(jump), .jump_target(jump_target),
        .branch(branch), .branch_target(branch_target),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready), .drop_count(drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle: log handshakes before the edge, then update the icache model.
    task automatic tick();
        logic        acc, pp;
        logic [31:0] a, p, i;
        #1;
        acc = req_valid & req_ready;
        a   = req_addr;
        pp  = out_valid & out_ready;
        p   = out_pc;
        i   = out_instr;
        if (acc) begin
            acc_log.push_back(a);
            pend_addr = a;
            pend_cnt  = lat;
        end
        if (pp) begin
            pop_pc.push_back(p);
            pop_ins.push_back(i);
            pop_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        rsp_valid = 1'b0;
        if (pend_cnt != 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_data  = pend_addr ^ MAGIC;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exception = 1'b0; jump = 1'b0; branch = 1'b0;
        exception_target = '0; jump_target = '0; branch_target = '0;
        rsp_valid = 1'b0; rsp_data = '0;
        pend_cnt = 0;
        acc_log.delete(); pop_pc.delete(); pop_ins.delete(); pop_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_ready = 1'b1; out_ready = 1'b1; lat = 3;
        exception = 1'b0; jump = 1'b0; branch = 1'b0;
        exception_target = '0; jump_target = '0; branch_target = '0;
        rsp_valid = 1'b0; rsp_data = '0; pend_cnt = 0; cyc = 0;
        repeat (2) @(posedge clk);
        #2;
        total_cnt++; if (req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", req_valid); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (drop_count !== 16'h0) $display("FAIL reset_drop_count: got %h want 0000", drop_count); else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h0) $display("FAIL reset_first_req: got vld=%b addr=%h want vld=1 addr=00000000", req_valid, req_addr); else pass_cnt++;
        tick();
        total_cnt++; if (req_valid !== 1'b0) $display("FAIL wait_no_req: got %b want 0", req_valid); else pass_cnt++;
        do_reset();
        total_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h0) $display("FAIL reset_mid_wait: got vld=%b addr=%h want vld=1 addr=00000000", req_valid, req_addr); else pass_cnt++;
    endtask

    task automatic test_stream();
        do_reset();
        lat = 1; req_ready = 1'b1; out_ready = 1'b1;
        repeat (7) tick();
        total_cnt++; if (acc_log.size() !== 4) $display("FAIL stream_accepts: got %0d want 4", acc_log.size()); else pass_cnt++;
        total_cnt++; if (pop_pc.size() !== 3) $display("FAIL stream_pops: got %0d want 3", pop_pc.size()); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (acc_log[k] !== 32'(4 * k) || pop_pc[k] !== 32'(4 * k) || pop_ins[k] !== (32'(4 * k) ^ MAGIC) || pop_cyc[k] !== 2 + 2 * k)
                $display("FAIL stream_entry%0d: got req=%h pc=%h instr=%h cyc=%0d want req=pc=%h instr=%h cyc=%0d",
                         k, acc_log[k], pop_pc[k], pop_ins[k], pop_cyc[k], 32'(4 * k), 32'(4 * k) ^ MAGIC, 2 + 2 * k);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        lat = 1; req_ready = 1'b1; out_ready = 1'b0;
        repeat (12) tick();
        total_cnt++; if (acc_log.size() !== 4) $display("FAIL stall_accepts: got %0d want 4", acc_log.size()); else pass_cnt++;
        total_cnt++; if (req_valid !== 1'b0 || dut.count_q !== 3'd4) $display("FAIL stall_full: got vld=%b count=%0d want vld=0 count=4", req_valid, dut.count_q); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1 || out_pc !== 32'h0) $display("FAIL stall_head: got vld=%b pc=%h want vld=1 pc=00000000", out_valid, out_pc); else pass_cnt++;
        out_ready = 1'b1;
        #1;
        total_cnt++; if (req_valid !== 1'b0) $display("FAIL stall_pop_same_cycle: got %b want 0", req_valid); else pass_cnt++;
        tick();
        out_ready = 1'b0;
        #1;
        total_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h10 || out_pc !== 32'h4) $display("FAIL stall_after_pop: got vld=%b addr=%h head=%h want vld=1 addr=00000010 head=00000004", req_valid, req_addr, out_pc); else pass_cnt++;
        repeat (6) tick();
        total_cnt++; if (acc_log.size() !== 5 || acc_log[4] !== 32'h10 || req_valid !== 1'b0) $display("FAIL stall_one_more: got n=%0d last=%h vld=%b want n=5 last=00000010 vld=0", acc_log.size(), acc_log[acc_log.size()-1], req_valid); else pass_cnt++;
    endtask

    task automatic test_branch_stale();
        do_reset();
        lat = 1; req_ready = 1'b1; out_ready = 1'b1;
        repeat (4) tick();
        lat = 5;
        total_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h8) $display("FAIL br_req8: got vld=%b addr=%h want vld=1 addr=00000008", req_valid, req_addr); else pass_cnt++;
        tick();
        branch = 1'b1; branch_target = 32'h103;
        tick();
        branch = 1'b0;
        total_cnt++; if (out_valid !== 1'b0 || req_valid !== 1'b0) $display("FAIL br_after_redirect: got out_vld=%b req_vld=%b want 0 0", out_valid, req_valid); else pass_cnt++;
        for (int n = 0; n < 20 && req_valid !== 1'b1; n++) tick();
        total_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h100 || cyc !== 10) $display("FAIL br_next_req: got vld=%b addr=%h cyc=%0d want vld=1 addr=00000100 cyc=10", req_valid, req_addr, cyc); else pass_cnt++;
        total_cnt++; if (drop_count !== 16'd1) $display("FAIL br_drop_count: got %0d want 1", drop_count); else pass_cnt++;
        for (int n = 0; n < 30 && pop_pc.size() < 3; n++) tick();
        total_cnt++; if (pop_pc.size() !== 3 || pop_pc[2] !== 32'h100 || pop_ins[2] !== 32'h1234_5770) $display("FAIL br_first_out: got n=%0d pc=%h instr=%h want n=3 pc=00000100 instr=12345770", pop_pc.size(), pop_pc[pop_pc.size()-1], pop_ins[pop_ins.size()-1]); else pass_cnt++;
    endtask

    task automatic test_priority();
        do_reset();
        lat = 1; req_ready = 1'b1; out_ready = 1'b0;
        repeat (6) tick();
        total_cnt++; if (dut.count_q !== 3'd3) $display("FAIL pri_queued: got %0d want 3", dut.count_q); else pass_cnt++;
        exception = 1'b1; exception_target = 32'h80;
        jump = 1'b1; jump_target = 32'h40;
        branch = 1'b1; branch_target = 32'h20;
        #1;
        total_cnt++; if (req_valid !== 1'b0) $display("FAIL pri_req_forced_low: got %b want 0", req_valid); else pass_cnt++;
        tick();
        exception = 1'b0; jump = 1'b0; branch = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h80) $display("FAIL pri_exception: got out_vld=%b req_vld=%b addr=%h want 0 1 00000080", out_valid, req_valid, req_addr); else pass_cnt++;
        jump = 1'b1; branch = 1'b1;
        tick();
        jump = 1'b0; branch = 1'b0;
        #1;
        total_cnt++; if (req_addr !== 32'h40 || acc_log.size() !== 3) $display("FAIL pri_jump_over_branch: got addr=%h n=%0d want addr=00000040 n=3", req_addr, acc_log.size()); else pass_cnt++;
    endtask

    task automatic test_rsp_jump();
        do_reset();
        lat = 2; req_ready = 1'b1; out_ready = 1'b1;
        tick();
        tick();
        jump = 1'b1; jump_target = 32'h200;
        tick();
        jump = 1'b0;
        #1;
        total_cnt++; if (drop_count !== 16'd1 || out_valid !== 1'b0) $display("FAIL rj_discard: got drop=%0d out_vld=%b want drop=1 out_vld=0", drop_count, out_valid); else pass_cnt++;
        total_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h200) $display("FAIL rj_resume: got vld=%b addr=%h want vld=1 addr=00000200", req_valid, req_addr); else pass_cnt++;
        repeat (4) tick();
        total_cnt++; if (pop_pc.size() !== 1 || pop_pc[0] !== 32'h200 || drop_count !== 16'd1) $display("FAIL rj_first_out: got n=%0d pc=%h drop=%0d want n=1 pc=00000200 drop=1", pop_pc.size(), pop_pc[0], drop_count); else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        lat = 1; req_ready = 1'b1; out_ready = 1'b1;
        branch = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch = 1'b0;
        #1;
        total_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_top: got vld=%b addr=%h want vld=1 addr=fffffffc", req_valid, req_addr); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h0) $display("FAIL wrap_zero: got vld=%b addr=%h want vld=1 addr=00000000", req_valid, req_addr); else pass_cnt++;
        tick();
        total_cnt++; if (pop_pc.size() !== 1 || pop_pc[0] !== 32'hFFFF_FFFC || pop_ins[0] !== 32'hEDCB_A98C) $display("FAIL wrap_out: got n=%0d pc=%h instr=%h want n=1 pc=fffffffc instr=edcba98c", pop_pc.size(), pop_pc[0], pop_ins[0]); else pass_cnt++;
    endtask

    task automatic test_drop_sat();
        do_reset();
        lat = 1; req_ready = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            tick();
            branch = 1'b1; branch_target = 32'h0;
            tick();
            branch = 1'b0;
            if (i == 65533) begin
                total_cnt++; if (drop_count !== 16'hFFFE) $display("FAIL sat_before: got %h want fffe", drop_count); else pass_cnt++;
            end
        end
        total_cnt++; if (drop_count !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", drop_count); else pass_cnt++;
        total_cnt++; if (acc_log.size() !== 65540) $display("FAIL sat_accepts: got %0d want 65540", acc_log.size()); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_stream();
        test_stall();
        test_branch_stale();
        test_priority();
        test_rsp_jump();
        test_wrap();
        test_drop_sat();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
